// File: rtl/issue_grant_latch.sv
// Issue-to-register-read pipeline latch for one issue-queue partition.
// It encodes the one-hot grant, muxes the payload, returns a free pulse on accepted issue and flags grant-protocol errors.
module issue_grant_latch #(
  parameter int unsigned IQ_SIZE   = 32,
  parameter int unsigned IQ_IDX_W  = $clog2(IQ_SIZE),
  parameter int unsigned PAYLOAD_W = 64,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush_i,
  input  logic                           stall_i,
  input  logic [IQ_SIZE-1:0]             grant_i,
  input  logic [IQ_SIZE-1:0]             entry_valid_i,
  input  logic [IQ_SIZE*PAYLOAD_W-1:0]   payload_i,
  output logic                           issue_valid_o,
  output logic [IQ_IDX_W-1:0]            issue_idx_o,
  output logic [PAYLOAD_W-1:0]           issue_payload_o,
  output logic                           free_valid_o,
  output logic [IQ_IDX_W-1:0]            free_idx_o,
  output logic                           grant_err_o,
  output logic [CNT_W-1:0]               issue_count_o
);

  logic [IQ_IDX_W-1:0]  sel;
  logic                 sel_found;
  logic                 gnt_any;
  logic                 sel_valid;
  logic                 multi_hot;
  logic                 proto_err;
  logic                 acc;
  logic [PAYLOAD_W-1:0] sel_payload;

  // Lowest set grant bit wins, so a multi-hot grant still issues deterministically.
  always_comb begin
    sel       = '0;
    sel_found = 1'b0;
    for (int unsigned i = 0; i < IQ_SIZE; i++) begin
      if (grant_i[i] && !sel_found) begin
        sel       = IQ_IDX_W'(i);
        sel_found = 1'b1;
      end
    end
  end

  always_comb begin
    gnt_any     = |grant_i;
    sel_valid   = entry_valid_i[sel];
    multi_hot   = |(grant_i & (grant_i - IQ_SIZE'(1)));
    proto_err   = multi_hot | (gnt_any & ~sel_valid);
    acc         = gnt_any & sel_valid & ~stall_i & ~flush_i;
    sel_payload = payload_i[sel*PAYLOAD_W +: PAYLOAD_W];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issue_valid_o   <= 1'b0;
      issue_idx_o     <= '0;
      issue_payload_o <= '0;
      free_valid_o    <= 1'b0;
      free_idx_o      <= '0;
      grant_err_o     <= 1'b0;
      issue_count_o   <= '0;
    end else begin
      if (proto_err) begin
        grant_err_o <= 1'b1;
      end
      if (flush_i) begin
        issue_valid_o <= 1'b0;
        free_valid_o  <= 1'b0;
      end else if (stall_i) begin
        // Held op stays in the latch; the dropped grant re-requests from the IQ.
        free_valid_o <= 1'b0;
      end else if (acc) begin
        issue_valid_o   <= 1'b1;
        issue_idx_o     <= sel;
        issue_payload_o <= sel_payload;
        free_valid_o    <= 1'b1;
        free_idx_o      <= sel;
        issue_count_o   <= issue_count_o + CNT_W'(1);
      end else begin
        issue_valid_o <= 1'b0;
        free_valid_o  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_issue_grant_latch.sv
// Directed-vector bench for issue_grant_latch; a second instance with a 4-bit counter exercises counter wrap.
module tb_issue_grant_latch;

  localparam int unsigned IQ_SIZE   = 32;
  localparam int unsigned IQ_IDX_W  = 5;
  localparam int unsigned PAYLOAD_W = 64;

  logic                          clk;
  logic                          reset;
  logic                          flush_i;
  logic                          stall_i;
  logic [IQ_SIZE-1:0]            grant_i;
  logic [IQ_SIZE-1:0]            entry_valid_i;
  logic [IQ_SIZE*PAYLOAD_W-1:0]  payload_i;

  logic                  issue_valid_o;
  logic [IQ_IDX_W-1:0]   issue_idx_o;
  logic [PAYLOAD_W-1:0]  issue_payload_o;
  logic                  free_valid_o;
  logic [IQ_IDX_W-1:0]   free_idx_o;
  logic                  grant_err_o;
  logic [15:0]           issue_count_o;

  logic                  w_issue_valid;
  logic [IQ_IDX_W-1:0]   w_issue_idx;
  logic [PAYLOAD_W-1:0]  w_issue_payload;
  logic                  w_free_valid;
  logic [IQ_IDX_W-1:0]   w_free_idx;
  logic                  w_grant_err;
  logic [3:0]            w_issue_count;

  int unsigned n_vec;
  int unsigned n_miss;

  issue_grant_latch #(
    .IQ_SIZE   (IQ_SIZE),
    .IQ_IDX_W  (IQ_IDX_W),
    .PAYLOAD_W (PAYLOAD_W),
    .CNT_W     (16)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .flush_i         (flush_i),
    .stall_i         (stall_i),
    .grant_i         (grant_i),
    .entry_valid_i   (entry_valid_i),
    .payload_i       (payload_i),
    .issue_valid_o   (issue_valid_o),
    .issue_idx_o     (issue_idx_o),
    .issue_payload_o (issue_payload_o),
    .free_valid_o    (free_valid_o),
    .free_idx_o      (free_idx_o),
    .grant_err_o     (grant_err_o),
    .issue_count_o   (issue_count_o)
  );

  issue_grant_latch #(
    .IQ_SIZE   (IQ_SIZE),
    .IQ_IDX_W  (IQ_IDX_W),
    .PAYLOAD_W (PAYLOAD_W),
    .CNT_W     (4)
  ) dut_w (
    .clk             (clk),
    .reset           (reset),
    .flush_i         (flush_i),
    .stall_i         (stall_i),
    .grant_i         (grant_i),
    .entry_valid_i   (entry_valid_i),
    .payload_i       (payload_i),
    .issue_valid_o   (w_issue_valid),
    .issue_idx_o     (w_issue_idx),
    .issue_payload_o (w_issue_payload),
    .free_valid_o    (w_free_valid),
    .free_idx_o      (w_free_idx),
    .grant_err_o     (w_grant_err),
    .issue_count_o   (w_issue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [4:0] idx,
                         input logic [63:0] pl, input logic fv, input logic [4:0] fidx,
                         input logic err, input logic [15:0] cnt);
    chk({tag, ".issue_valid"}, 64'(issue_valid_o), 64'(v));
    chk({tag, ".issue_idx"}, 64'(issue_idx_o), 64'(idx));
    chk({tag, ".issue_payload"}, issue_payload_o, pl);
    chk({tag, ".free_valid"}, 64'(free_valid_o), 64'(fv));
    chk({tag, ".free_idx"}, 64'(free_idx_o), 64'(fidx));
    chk({tag, ".grant_err"}, 64'(grant_err_o), 64'(err));
    chk({tag, ".count"}, 64'(issue_count_o), 64'(cnt));
  endtask

  initial begin
    n_vec         = 0;
    n_miss        = 0;
    reset         = 1'b0;
    flush_i       = 1'b0;
    stall_i       = 1'b0;
    grant_i       = '0;
    entry_valid_i = '1;
    for (int k = 0; k < 32; k++) payload_i[k*64 +: 64] = 64'h1000 + 64'(k);
    payload_i[8*64 +: 64] = 64'hDEAD;
    payload_i[2*64 +: 64] = 64'hBEEF;

    #12;
    chk_out("reset", 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 1'b0, 16'd0);
    step();
    reset = 1'b1;

    // T1: single grant of entry 8
    grant_i = 32'h0000_0100;
    step();
    chk_out("t1", 1'b1, 5'd8, 64'hDEAD, 1'b1, 5'd8, 1'b0, 16'd1);

    // T2: stall for three cycles with grant on entry 3
    stall_i = 1'b1;
    grant_i = 32'h0000_0008;
    for (int c = 0; c < 3; c++) begin
      step();
      chk_out("t2", 1'b1, 5'd8, 64'hDEAD, 1'b0, 5'd8, 1'b0, 16'd1);
    end
    stall_i = 1'b0;
    grant_i = '0;
    step();
    chk_out("bubble", 1'b0, 5'd8, 64'hDEAD, 1'b0, 5'd8, 1'b0, 16'd1);

    // T4: accept entry 6, then flush+stall with grant on entry 5
    grant_i = 32'h0000_0040;
    step();
    chk_out("t4_pre", 1'b1, 5'd6, 64'h1006, 1'b1, 5'd6, 1'b0, 16'd2);
    flush_i = 1'b1;
    stall_i = 1'b1;
    grant_i = 32'h0000_0020;
    step();
    chk_out("t4", 1'b0, 5'd6, 64'h1006, 1'b0, 5'd6, 1'b0, 16'd2);
    flush_i = 1'b0;
    stall_i = 1'b0;

    // T5: grant of an unoccupied entry
    grant_i       = 32'h0000_0080;
    entry_valid_i = ~32'h0000_0080;
    step();
    chk_out("t5", 1'b0, 5'd6, 64'h1006, 1'b0, 5'd6, 1'b1, 16'd2);
    grant_i       = '0;
    entry_valid_i = '1;
    step();
    chk("t5_sticky", 64'(grant_err_o), 64'd1);

    // Asynchronous reset asserted mid-cycle while a stalled op is held
    grant_i = 32'h0000_0200;
    step();
    chk_out("pre_rst", 1'b1, 5'd9, 64'h1009, 1'b1, 5'd9, 1'b1, 16'd3);
    stall_i = 1'b1;
    step();
    #2;
    reset = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 1'b0, 16'd0);
    stall_i = 1'b0;
    grant_i = '0;
    step();
    reset = 1'b1;

    // T3: multi-hot grant issues the lowest index and raises the sticky error
    grant_i = 32'h0000_0014;
    step();
    chk_out("t3", 1'b1, 5'd2, 64'hBEEF, 1'b1, 5'd2, 1'b1, 16'd1);
    grant_i = '0;
    step();
    chk_out("t3_after", 1'b0, 5'd2, 64'hBEEF, 1'b0, 5'd2, 1'b1, 16'd1);

    // T6: back-to-back accepts drive the 4-bit counter to its wrap point
    for (int c = 0; c < 14; c++) begin
      grant_i = 32'h1 << (c + 10);
      step();
    end
    chk("t6_pre16", 64'(issue_count_o), 64'd15);
    chk("t6_pre4", 64'(w_issue_count), 64'd15);
    chk("t6_free_last", 64'(free_idx_o), 64'd23);
    grant_i = 32'h8000_0000;
    step();
    chk("t6_wrap4", 64'(w_issue_count), 64'd0);
    chk("t6_cnt16", 64'(issue_count_o), 64'd16);
    chk("t6_idx", 64'(issue_idx_o), 64'd31);
    chk("t6_payload", issue_payload_o, 64'h101F);
    grant_i = '0;
    step();
    chk("t6_free_drop", 64'(free_valid_o), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
